// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-path arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational request picker: one-hot grant plus binary index of the winner.
// AXI_RD_ARB_RR_EN selects a round-robin search from ptr_i; otherwise lowest index wins.
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M = 4,
    parameter int IDX_W = idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
`ifdef AXI_RD_ARB_RR_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [NUM_M-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_s;

    // Walk candidates from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        idx_s  = '0;
        cand_s = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
`ifdef AXI_RD_ARB_RR_EN
            cand_s = IDX_W'((int'(ptr_i) + k) % NUM_M);
`else
            cand_s = IDX_W'(k);
`endif
            if (req_i[cand_s]) begin
                idx_s = cand_s;
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // One-hot form of the winner, empty when nobody requests.
    always_comb begin
        gnt_o = '0;
        if (|req_i) begin
            gnt_o[idx_s] = 1'b1;
        end else begin
            gnt_o = '0;
        end
    end

    assign idx_o = idx_s;

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI read-path arbiter: shares one slave AR/R channel among NUM_M masters, one burst at a time.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_M*ID_WIDTH-1:0]     s_arid,
    input  logic [NUM_M*ADDR_WIDTH-1:0]   s_araddr,
    input  logic [NUM_M*LEN_W-1:0]        s_arlen,
    input  logic [NUM_M*SIZE_W-1:0]       s_arsize,
    input  logic [NUM_M*BURST_W-1:0]      s_arburst,
    input  logic [NUM_M*PROT_W-1:0]       s_arprot,
    input  logic [NUM_M-1:0]              s_arvalid,
    output logic [NUM_M-1:0]              s_arready,
    output logic [ID_WIDTH-1:0]           s_rid,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [RESP_W-1:0]             s_rresp,
    output logic                          s_rlast,
    output logic [NUM_M-1:0]              s_rvalid,
    input  logic [NUM_M-1:0]              s_rready,
    output logic [ID_WIDTH-1:0]           m_arid,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [LEN_W-1:0]              m_arlen,
    output logic [SIZE_W-1:0]             m_arsize,
    output logic [BURST_W-1:0]            m_arburst,
    output logic [PROT_W-1:0]             m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [ID_WIDTH-1:0]           m_rid,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [RESP_W-1:0]             m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [NUM_M-1:0]              grant
);

    localparam int IDX_W = idx_w(NUM_M);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [NUM_M-1:0] arb_gnt_s;
    logic [IDX_W-1:0] arb_idx_s;

    logic [ID_WIDTH-1:0]   arid_s    [NUM_M];
    logic [ADDR_WIDTH-1:0] araddr_s  [NUM_M];
    logic [LEN_W-1:0]      arlen_s   [NUM_M];
    logic [SIZE_W-1:0]     arsize_s  [NUM_M];
    logic [BURST_W-1:0]    arburst_s [NUM_M];
    logic [PROT_W-1:0]     arprot_s  [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_slot
        assign arid_s[i]    = s_arid[i*ID_WIDTH +: ID_WIDTH];
        assign araddr_s[i]  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign arlen_s[i]   = s_arlen[i*LEN_W +: LEN_W];
        assign arsize_s[i]  = s_arsize[i*SIZE_W +: SIZE_W];
        assign arburst_s[i] = s_arburst[i*BURST_W +: BURST_W];
        assign arprot_s[i]  = s_arprot[i*PROT_W +: PROT_W];
    end

    // The AR payload always follows gidx, even in IDLE; only the valid is gated.
    assign m_arid    = arid_s[gidx_q];
    assign m_araddr  = araddr_s[gidx_q];
    assign m_arlen   = arlen_s[gidx_q];
    assign m_arsize  = arsize_s[gidx_q];
    assign m_arburst = arburst_s[gidx_q];
    assign m_arprot  = arprot_s[gidx_q];

    assign s_rid   = m_rid;
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

`ifdef AXI_RD_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Round-robin pointer: where the next search begins.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    axi_rr_arbiter #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (s_arvalid),
`ifdef AXI_RD_ARB_RR_EN
        .ptr_i (ptr_q),
`endif
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s)
    );

    // FSM state and grant index registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
        end
    end

    // Next state and channel routing; a master that drops arvalid in ADDR just stalls there.
    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        m_arvalid = 1'b0;
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        grant     = '0;
`ifdef AXI_RD_ARB_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|arb_gnt_s) begin
                    gidx_d  = arb_idx_s;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                grant[gidx_q]     = 1'b1;
                m_arvalid         = s_arvalid[gidx_q];
                s_arready[gidx_q] = m_arready;
                if (s_arvalid[gidx_q] && m_arready) begin
                    state_d = DATA;
                end else begin
                    state_d = ADDR;
                end
            end
            DATA: begin
                grant[gidx_q]    = 1'b1;
                s_rvalid[gidx_q] = m_rvalid;
                m_rready         = s_rready[gidx_q];
                if (m_rvalid && s_rready[gidx_q] && m_rlast) begin
                    state_d = IDLE;
`ifdef AXI_RD_ARB_RR_EN
                    ptr_d = (gidx_q == IDX_W'(NUM_M - 1)) ? '0 : gidx_q + IDX_W'(1);
`endif
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
                gidx_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural owner/phase model.
module tb_axi_rd_arbiter;
    import axi_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*IW-1:0]  s_arid;
    logic [N*AW-1:0]  s_araddr;
    logic [N*8-1:0]   s_arlen;
    logic [N*3-1:0]   s_arsize;
    logic [N*2-1:0]   s_arburst;
    logic [N*3-1:0]   s_arprot;
    logic [N-1:0]     s_arvalid;
    logic [N-1:0]     s_arready;
    logic [IW-1:0]    s_rid;
    logic [DW-1:0]    s_rdata;
    logic [1:0]       s_rresp;
    logic             s_rlast;
    logic [N-1:0]     s_rvalid;
    logic [N-1:0]     s_rready;
    logic [IW-1:0]    m_arid;
    logic [AW-1:0]    m_araddr;
    logic [7:0]       m_arlen;
    logic [2:0]       m_arsize;
    logic [1:0]       m_arburst;
    logic [2:0]       m_arprot;
    logic             m_arvalid;
    logic             m_arready;
    logic [IW-1:0]    m_rid;
    logic [DW-1:0]    m_rdata;
    logic [1:0]       m_rresp;
    logic             m_rlast;
    logic             m_rvalid;
    logic             m_rready;
    logic [N-1:0]     grant;

    axi_rd_arbiter #(.NUM_M(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .grant(grant)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Winner = first requester found scanning upward (with wrap) from p.
    function automatic int pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            if (bitof(req, (p + k) % N)) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int owner = -1;     // -1: nobody owns the slave
    bit sent  = 1'b0;   // owner's AR already accepted
    int ptr   = 0;
    logic [N-1:0] exp_g;
    logic [N-1:0] hs_sar;
    bit           hs_mar, hs_r;
    logic [7:0]   hs_len;

    always @(negedge clk) begin
        if (!rst_n) begin
            owner  = -1;
            sent   = 1'b0;
            ptr    = 0;
            hs_sar = '0;
            hs_mar = 1'b0;
            hs_r   = 1'b0;
        end else begin
            exp_g = (owner < 0) ? {N{1'b0}} : N'(1 << owner);
            chk("m_grant", grant, exp_g);
            if (owner >= 0 && !sent) begin
                chk("m_arvalid", m_arvalid, bitof(s_arvalid, owner));
                chk("m_s_arready", s_arready, m_arready ? exp_g : {N{1'b0}});
                chk("m_araddr", m_araddr, AW'(s_araddr >> (owner * AW)));
                chk("m_arlen", m_arlen, 8'(s_arlen >> (owner * 8)));
                chk("m_arid", m_arid, IW'(s_arid >> (owner * IW)));
                chk("m_arburst", m_arburst, 2'(s_arburst >> (owner * 2)));
            end else begin
                chk("m_arvalid_off", m_arvalid, 1'b0);
                chk("m_s_arready_off", s_arready, {N{1'b0}});
            end
            if (owner >= 0 && sent) begin
                chk("m_s_rvalid", s_rvalid, m_rvalid ? exp_g : {N{1'b0}});
                chk("m_rready", m_rready, bitof(s_rready, owner));
            end else begin
                chk("m_s_rvalid_off", s_rvalid, {N{1'b0}});
                chk("m_rready_off", m_rready, 1'b0);
            end
            chk("m_rdata", s_rdata, m_rdata);
            chk("m_rid", s_rid, m_rid);
            chk("m_rlast", s_rlast, m_rlast);
            chk("m_rresp", s_rresp, m_rresp);

            hs_sar = s_arvalid & s_arready;
            hs_mar = m_arvalid & m_arready;
            hs_len = m_arlen;
            hs_r   = m_rvalid & m_rready;

            if (owner < 0) begin
                if (s_arvalid != '0) begin
                    owner = pick(s_arvalid, ptr);
                    sent  = 1'b0;
                end
            end else if (!sent) begin
                if (bitof(s_arvalid, owner) && m_arready) sent = 1'b1;
            end else if (m_rvalid && bitof(s_rready, owner) && m_rlast) begin
`ifdef AXI_RD_ARB_RR_EN
                ptr = (owner + 1) % N;
`endif
                owner = -1;
                sent  = 1'b0;
            end
        end
    end

    // ---------------- random traffic driver ----------------
    bit          rnd_en  = 1'b0;
    bit          sl_busy = 1'b0;
    int          sl_len  = 0;
    int          sl_beat = 0;
    logic [DW-1:0] sl_data = 32'h0000_5000;
    logic [1:0]  resp_tab  [4] = '{RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR};
    logic [1:0]  burst_tab [3] = '{BURST_FIXED, BURST_INCR, BURST_WRAP};

    task automatic drive_random();
        if (hs_r) begin
            sl_beat++;
            sl_data++;
            if (sl_beat == sl_len) sl_busy = 1'b0;
        end
        if (hs_mar) begin
            sl_busy = 1'b1;
            sl_len  = int'(hs_len) + 1;
            sl_beat = 0;
        end
        if (!m_rvalid || hs_r) begin
            if (sl_busy && $urandom_range(0, 3) != 0) begin
                m_rvalid = 1'b1;
                m_rdata  = sl_data;
                m_rlast  = (sl_beat == sl_len - 1);
                m_rid    = IW'($urandom);
                m_rresp  = resp_tab[$urandom_range(0, 3)];
            end else begin
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
            end
        end
        m_arready = 1'($urandom_range(0, 1));
        s_rready  = N'($urandom);
        for (int i = 0; i < N; i++) begin
            if (hs_sar[i]) s_arvalid[i] = 1'b0;
            if (!s_arvalid[i] && $urandom_range(0, 3) == 0) begin
                s_arvalid[i]            = 1'b1;
                s_araddr[i*AW +: AW]    = $urandom;
                s_arlen[i*8 +: 8]       = 8'($urandom_range(0, 3));
                s_arid[i*IW +: IW]      = IW'($urandom);
                s_arsize[i*3 +: 3]      = 3'($urandom_range(0, 2));
                s_arburst[i*2 +: 2]     = burst_tab[$urandom_range(0, 2)];
                s_arprot[i*3 +: 3]      = 3'($urandom);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) drive_random();
        end
    end

    // ---------------- directed helpers ----------------
    task automatic set_slot(input int i, input logic [31:0] a, input logic [7:0] len);
        s_araddr[i*AW +: AW] = a;
        s_arlen[i*8 +: 8]    = len;
        s_arid[i*IW +: IW]   = IW'(i + 5);
        s_arsize[i*3 +: 3]   = 3'd2;
        s_arburst[i*2 +: 2]  = BURST_INCR;
        s_arprot[i*3 +: 3]   = 3'd0;
    endtask

    // IDLE cycle with request, then ADDR accepted, leaves caller in the first DATA cycle.
    task automatic do_ar(input int i, input logic [31:0] a, input logic [7:0] len);
        tick();
        set_slot(i, a, len);
        s_arvalid = N'(1 << i);
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        s_arvalid = '0;
    endtask

    // Caller has just raised requests; serves one single-beat burst and counts IDLE cycles.
    task automatic serve_one(input bit drop, output logic [N-1:0] g, output int idle);
        idle = 0;
        g    = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (grant != '0) break;
            idle++;
            tick();
        end
        g = grant;
        tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        m_rdata   = $urandom;
        tick();
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        if (drop) s_arvalid = '0;
    endtask

    logic [DW-1:0] rx[$];
    logic [N-1:0]  g;
    int            idle;
    int            b;
    logic [N-1:0]  cont_req;
    logic [N-1:0]  cont_exp [5];

    initial begin
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arprot = '0;
        s_arvalid = '0; s_rready = '0; m_arready = 1'b0; m_rid = '0; m_rdata = '0;
        m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_s_arready", s_arready, 4'b0000);
        chk("rst_s_rvalid", s_rvalid, 4'b0000);
        chk("rst_m_rready", m_rready, 1'b0);
        tick();
        rst_n = 1'b1;

        // single request from master 2, 4-beat burst
        tick();
        set_slot(2, 32'h0000_1000, 8'd3);
        s_arvalid = 4'b0100;
        s_rready  = 4'b0100;
        tick();
        @(negedge clk);
        chk("t1_arvalid", m_arvalid, 1'b1);
        chk("t1_araddr", m_araddr, 32'h0000_1000);
        chk("t1_arlen", m_arlen, 8'd3);
        chk("t1_grant_addr", grant, 4'b0100);
        tick();
        m_arready = 1'b1;
        @(negedge clk);
        chk("t1_arready", s_arready, 4'b0100);
        tick();
        m_arready = 1'b0;
        s_arvalid = '0;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'h0000_00A0 + 32'(k);
            m_rlast  = (k == 3);
            @(negedge clk);
            chk("t1_rvalid", s_rvalid, 4'b0100);
            chk("t1_rdata", s_rdata, 32'h0000_00A0 + 32'(k));
            chk("t1_grant_data", grant, 4'b0100);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        @(negedge clk);
        chk("t1_idle_grant", grant, 4'b0000);

        // backpressure: master 0 holds rready low for 5 cycles mid-burst
        do_ar(0, 32'h0000_2000, 8'd3);
        b = 0;
        for (int c = 0; c < 24 && b < 4; c++) begin
            s_rready = (c >= 1 && c <= 5) ? 4'b0000 : 4'b0001;
            m_rvalid = 1'b1;
            m_rdata  = 32'h0000_00B0 + 32'(b);
            m_rlast  = (b == 3);
            @(negedge clk);
            if (c >= 1 && c <= 5) begin
                chk("bp_rready_low", m_rready, 1'b0);
                chk("bp_rvalid_held", s_rvalid, 4'b0001);
            end else begin
                chk("bp_rready_high", m_rready, 1'b1);
            end
            if (s_rvalid[0] && s_rready[0]) begin
                rx.push_back(s_rdata);
                b++;
            end
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("bp_beats", rx.size(), 4);
        for (int k = 0; k < rx.size(); k++) chk("bp_order", rx[k], 32'h0000_00B0 + 32'(k));

        // stray slave R beat while IDLE
        s_rready = 4'b1111;
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD_0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stray_rready", m_rready, 1'b0);
            chk("stray_rvalid", s_rvalid, 4'b0000);
            tick();
        end
        m_rvalid = 1'b0;

        // reset mid-burst after beat 0 handshake, during beat 1
        do_ar(1, 32'h0000_3000, 8'd3);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0000_00C0;
        tick();
        m_rdata  = 32'h0000_00C1;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("rstmid_grant", grant, 4'b0000);
        chk("rstmid_arvalid", m_arvalid, 1'b0);
        chk("rstmid_arready", s_arready, 4'b0000);
        chk("rstmid_rvalid", s_rvalid, 4'b0000);
        chk("rstmid_rready", m_rready, 1'b0);
        tick();
        rst_n    = 1'b1;
        m_rvalid = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", grant, 4'b0000);
        tick();
        set_slot(3, 32'h0000_4000, 8'd0);
        s_arvalid = 4'b1000;
        serve_one(1'b1, g, idle);
        chk("rstmid_new_grant", g, 4'b1000);
        chk("rstmid_new_bubble", idle, 1);

        // contention with single-beat bursts
`ifdef AXI_RD_ARB_RR_EN
        cont_req = 4'b1111;
        cont_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        cont_req = 4'b1010;
        cont_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        tick();
        for (int i = 0; i < N; i++) set_slot(i, 32'h0000_6000 + 32'(i * 16), 8'd0);
        s_arvalid = cont_req;
        for (int n = 0; n < 5; n++) begin
            serve_one(n == 4, g, idle);
            chk("cont_grant", g, cont_exp[n]);
            chk("cont_bubble", idle, 1);
        end

        // randomized traffic against the model
        @(negedge clk);
        rnd_en = 1'b1;
        repeat (3000) @(posedge clk);
        @(negedge clk);
        rnd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-path arbiter that shares one AXI slave's AR and R channels among NUM_M requesting masters. One burst is in flight at a time: the block grants one master, forwards its AR beat, then routes all R beats back to it until RLAST, then re-arbitrates. It sits between the master-side `axi_if` instances (MASTER modport) and a single slave-side `axi_if` (SLAVE modport), with per-master AR/R signals flattened into vectors.

## Interface
- NUM_M, 4, number of requesting masters (≥1); IDX_W = max(1, $clog2(NUM_M))
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, read data width
- ID_WIDTH, 4, transaction ID width, passed through unchanged
- ACLK  in  1  clock; all logic on the rising edge
- ARESETn  in  1  asynchronous, active-low reset
- s_arid / s_araddr / s_arlen / s_arsize / s_arburst / s_arprot  in  NUM_M× field width  per-master AR payload; slot i at [i*W +: W]
- s_arvalid  in  NUM_M  per-master AR valid
- s_arready  out  NUM_M  per-master AR ready
- s_rid / s_rdata / s_rresp / s_rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  R payload broadcast to all masters
- s_rvalid  out  NUM_M  per-master R valid
- s_rready  in  NUM_M  per-master R ready
- m_arid / m_araddr / m_arlen / m_arsize / m_arburst / m_arprot  out  field widths  AR payload to slave
- m_arvalid  out  1;  m_arready  in  1
- m_rid / m_rdata / m_rresp / m_rlast / m_rvalid  in  field widths;  m_rready  out  1
- grant  out  NUM_M  one-hot owner of the slave; 0 when IDLE

## Operation
- FSM: IDLE, ADDR, DATA. The grant index register gidx (IDX_W bits) selects the payload mux.
- IDLE: if any s_arvalid is set, the sub-arbiter picks a winner. Load gidx and go to ADDR. Otherwise stay in IDLE.
- ADDR: m_arvalid = s_arvalid[gidx]; m_ar* = slot gidx; s_arready[gidx] = m_arready; other s_arready bits are 0. On m_arvalid & m_arready, go to DATA.
- DATA: s_rvalid[gidx] = m_rvalid; m_rready = s_rready[gidx]; s_r* = m_r*. On m_rvalid & m_rready & m_rlast, go to IDLE and update the priority pointer.
- Outside DATA: m_rready = 0 and all s_rvalid = 0. Stray slave R beats stall; they are never dropped.
- Non-granted masters never see arready or rvalid.
- IDs pass through unmodified. Routing uses gidx only, never RID.
- s_arvalid[gidx] deasserting in ADDR is a master protocol violation. The block stays in ADDR with m_arvalid low.
- grant = one-hot(gidx) in ADDR/DATA, 0 in IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, gidx 0, priority pointer 0, grant 0. The following are all 0: m_arvalid, s_arready, s_rvalid, m_rready. Payload outputs show slot 0 / m_r* through the mux.
- Reset mid-burst aborts it. The slave is expected to be reset by the same ARESETn.
- AR latency: s_arvalid high in cycle 0 while IDLE, then m_arvalid high in cycle 1. The arbiter adds no further delay.
- After the RLAST handshake in cycle N, the FSM is IDLE in N+1 and the next m_arvalid is possible in N+2. There is one IDLE bubble per burst.
- Backpressure passes through combinationally in both directions. There is no buffering.
- Simultaneous requests in IDLE: only one winner. Losers hold s_arvalid and are served in later IDLE cycles.

## Configuration
- AXI_RD_ARB_RR_EN defined: round-robin. After each completed burst, the pointer moves to gidx+1, wrapping from NUM_M-1 to 0. The search starts at the pointer.
- AXI_RD_ARB_RR_EN undefined: fixed priority, lowest index wins. The pointer register is not built.

## Structure
- Package axi_arb_pkg holds:
  - the state enum arb_state_e {IDLE, ADDR, DATA};
  - AXI burst/resp localparams;
  - the function idx_w(n).
- Sub-module axi_rr_arbiter: combinational request vector + pointer, producing a one-hot grant and a binary index. It is instantiated once. The ifdef lives inside it.

## Test plan
- Single request: master 2 issues ARADDR 0x1000, ARLEN 3 → m_arvalid in the next cycle with addr 0x1000. Four R beats reach only s_rvalid[2], and grant = 0b0100 throughout.
- Contention, RR build: all four masters hold arvalid with ARLEN 0 → grant order 0,1,2,3,0. Each burst is followed by exactly one IDLE cycle.
- Contention, fixed-priority build: masters 1 and 3 request continuously → master 1 is always served and master 3 is never served.
- Backpressure: s_rready[gidx] is low for 5 cycles mid-burst → m_rready is low for those same cycles, and RDATA order is preserved.
- Stray R: the slave raises m_rvalid while IDLE → m_rready stays 0 and all s_rvalid stay 0.
- Reset mid-burst: ARESETn is pulsed low during DATA after beat 1 of 4 → the next cycle shows IDLE with grant 0 and all valids/readies 0. A new request is then served normally.
